// File: rtl/tipi_sout_pkg.sv
// Shared definitions for the TIPI serial-out arbiter: FSM state encoding and
// default geometry.
package tipi_sout_pkg;

    // Binary state encoding, two bits
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DEF_NREQ  = 3;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNTW  = 4;

endpackage

// File: rtl/sout_shifter.sv
// WIDTH-bit parallel-load, shift-left register. The MSB is the serial bit.
// Priority: clear over load over shift.
module sout_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    // Shift register update: clear wins, then load, then shift one bit left
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/tipi_sout_arbiter.sv
// Round-robin arbiter that shares one MSB-first serial output among NREQ
// byte sources. A granted source's byte is parallel-loaded, shifted out one
// bit per bit_tick, and the owner gets a one-cycle ack when all bits are out.
//
// Handshake: req is a level; the arbiter samples it only in IDLE. grant is
// one-hot and held from LOAD through DONE; the owner may drop req at any time
// without cancelling the transfer. ack pulses for exactly the DONE cycle.
// abort cancels a transfer with no ack. state_dbg exposes the FSM state.
module tipi_sout_arbiter
    import tipi_sout_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    input  logic                  bit_tick,
    input  logic                  abort,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic                  sout,
    output logic [CNTW-1:0]       bit_cnt,
    output logic [1:0]            state_dbg
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              busy_q, busy_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [IDXW-1:0]   rr_q, rr_d;
    logic [IDXW-1:0]   pick;
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  shift_q;
    logic              sh_load, sh_shift, sh_clear;

    // First requester scanning upward from last+1, wrapping modulo NREQ
    function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                 input logic [IDXW-1:0] last);
        logic [IDXW-1:0] p;
        logic            found;
        int              idx;
        p     = last;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && (|(r & (NREQ'(1) << idx)))) begin
                p     = IDXW'(idx);
                found = 1'b1;
            end
        end
        return p;
    endfunction

    // Owner index is rr_q once granted; select its byte for the load
    assign pick     = rr_pick(req, rr_q);
    assign sel_data = data[int'(rr_q)*WIDTH +: WIDTH];

    // Next-state, registered-output and shifter-enable decode
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ack_d    = '0;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_clear = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!abort && (|req)) begin
                    rr_d    = pick;
                    grant_d = NREQ'(1) << pick;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    sh_clear = 1'b1;
                end else begin
                    sh_load = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    sh_clear = 1'b1;
                end else if (bit_tick) begin
                    sh_shift = 1'b1;
                    cnt_d    = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(WIDTH - 1)) begin
                        state_d = S_DONE;
                        ack_d   = grant_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                if (abort) begin
                    cnt_d    = '0;
                    sh_clear = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; rr_last resets so source 0 goes first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            rr_q    <= IDXW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    sout_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (sh_load),
        .shift   (sh_shift),
        .clear   (sh_clear),
        .din     (sel_data),
        .q       (shift_q)
    );

    assign grant     = grant_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign sout      = shift_q[WIDTH-1];
    assign bit_cnt   = cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_tipi_sout_arbiter.sv
// Bench for tipi_sout_arbiter: directed scenarios plus randomized transfers,
// checked against a transaction-level model of the arbitration and serial
// output rules.
module tb_tipi_sout_arbiter;

    localparam int NREQ = 3;
    localparam int W    = 8;
    localparam int CNTW = 4;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*W-1:0]    data;
    logic                 bit_tick;
    logic                 abort;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      ack;
    logic                 busy;
    logic                 sout;
    logic [CNTW-1:0]      bit_cnt;
    logic [1:0]           state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int rr_last;
    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    tipi_sout_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (W),
        .CNTW  (CNTW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .data      (data),
        .bit_tick  (bit_tick),
        .abort     (abort),
        .grant     (grant),
        .ack       (ack),
        .busy      (busy),
        .sout      (sout),
        .bit_cnt   (bit_cnt),
        .state_dbg (state_dbg)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference arbitration rule: first requester after the last owner, wrapping
    function automatic int model_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sout"}, 32'(sout), 32'd0);
        check({tag, "_bitcnt"}, 32'(bit_cnt), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        req      = '0;
        data     = '0;
        bit_tick = 1'b0;
        abort    = 1'b0;
        #1;
        check_all_zero("reset");
        step();
        reset_n = 1'b1;
        rr_last = NREQ - 1;
        exp_q.delete();
    endtask

    // One transfer from IDLE. *_at arguments give the tick index before which
    // the event happens (-1 = never).
    task automatic do_transfer(input logic [NREQ-1:0] r, input logic [NREQ*W-1:0] d,
                               input int gap_lo, input int gap_hi,
                               input int abort_at, input int drop_at, input int reset_at,
                               input bit tick_always, input bit keep_req);
        int owner;
        int gap;
        logic [W-1:0] bv;
        req      = r;
        data     = d;
        bit_tick = tick_always;
        step();
        owner   = model_pick(r, rr_last);
        rr_last = owner;
        exp_q.push_back(d[owner*W +: W]);
        check("grant", 32'(grant), 32'(1) << owner);
        check("busy_load", 32'(busy), 32'd1);
        check("ack_load", 32'(ack), 32'd0);
        step();
        bv = exp_q.pop_front();
        check("first_bit", 32'(sout), 32'(bv[W-1]));
        check("cnt_after_load", 32'(bit_cnt), 32'd0);
        for (int k = 0; k < W; k++) begin
            if (k == reset_at) begin
                #2;
                reset_n = 1'b0;
                #1;
                check_all_zero("async_reset");
                req      = '0;
                bit_tick = 1'b0;
                abort    = 1'b0;
                step();
                check_all_zero("reset_hold");
                reset_n = 1'b1;
                rr_last = NREQ - 1;
                return;
            end
            if (k == abort_at) begin
                abort    = 1'b1;
                bit_tick = 1'b1;
                step();
                abort    = 1'b0;
                bit_tick = 1'b0;
                req      = '0;
                check_all_zero("abort");
                step();
                check_idle("post_abort");
                return;
            end
            if (k == drop_at) req = '0;
            if (!tick_always) begin
                gap = int'($urandom_range(gap_hi, gap_lo));
                bit_tick = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    step();
                    check("cnt_hold", 32'(bit_cnt), 32'(k));
                    check("sout_hold", 32'(sout), 32'(bv[W-1-k]));
                end
                bit_tick = 1'b1;
                step();
                bit_tick = 1'b0;
            end else begin
                step();
            end
            check("cnt_step", 32'(bit_cnt), 32'(k + 1));
            if (k < W - 1) begin
                check("sout_bit", 32'(sout), 32'(bv[W-2-k]));
                check("ack_early", 32'(ack), 32'd0);
                check("busy_shift", 32'(busy), 32'd1);
            end else begin
                check("ack_done", 32'(ack), 32'(1) << owner);
                check("grant_done", 32'(grant), 32'(1) << owner);
                check("busy_done", 32'(busy), 32'd1);
                check("sout_done", 32'(sout), 32'd0);
            end
        end
        bit_tick = 1'b0;
        step();
        check_idle("after_done");
        check("state_after_done", 32'(state_dbg), 32'd0);
        if (!keep_req) req = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NREQ-1:0]   r;
        logic [NREQ*W-1:0] d;
        int ab, dr;
        bit ta;

        do_reset();

        // single source, A5, ticks every 3 cycles
        do_transfer(3'b001, {8'h11, 8'h22, 8'hA5}, 2, 2, -1, -1, -1, 1'b0, 1'b0);

        // round robin with 101 held, then 011
        do_reset();
        for (int n = 0; n < 4; n++) begin
            d = {$urandom(), $urandom()};
            do_transfer(3'b101, d, 0, 1, -1, -1, -1, 1'b0, 1'b1);
        end
        for (int n = 0; n < 2; n++) begin
            d = {$urandom(), $urandom()};
            do_transfer(3'b011, d, 0, 1, -1, -1, -1, 1'b0, n == 0);
        end

        // abort after 3 ticks of FF
        do_transfer(3'b001, {8'h00, 8'h00, 8'hFF}, 0, 2, 3, -1, -1, 1'b0, 1'b0);

        // abort in IDLE issues no grant
        req   = 3'b010;
        abort = 1'b1;
        step();
        abort = 1'b0;
        req   = '0;
        check_idle("abort_idle");
        step();

        // reset after 5 ticks
        do_transfer(3'b100, {8'hC3, 8'h00, 8'h00}, 0, 2, -1, -1, 5, 1'b0, 1'b0);

        // tick held high from before req
        do_transfer(3'b010, {8'h00, 8'h96, 8'h00}, 0, 0, -1, -1, -1, 1'b1, 1'b0);

        // req dropped after 2 ticks
        do_transfer(3'b100, {8'h3C, 8'h00, 8'h00}, 0, 2, -1, 2, -1, 1'b0, 1'b0);

        // randomized transfers
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(1, 0) == 1) begin
                bit_tick = 1'b1;
                step();
                bit_tick = 1'b0;
                check_idle("idle_tick");
            end
            r  = NREQ'($urandom_range(7, 1));
            d  = {$urandom(), $urandom()};
            ab = ($urandom_range(7, 0) == 0) ? int'($urandom_range(W - 1, 0)) : -1;
            dr = ($urandom_range(3, 0) == 0) ? int'($urandom_range(W - 1, 0)) : -1;
            ta = ($urandom_range(3, 0) == 0);
            do_transfer(r, d, 0, 3, ab, dr, -1, ta, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
